// File: rtl/mem_pkg.sv
// Shared types and defaults for the clearable single-port RAM.
package mem_pkg;

  // Clear-engine FSM states.
  typedef enum logic {
    MEM_IDLE  = 1'b0,
    MEM_CLEAR = 1'b1
  } mem_clr_state_e;

  // Default geometry: 8-bit words, 1024 entries.
  localparam int MEM_DW_DEF = 8;
  localparam int MEM_AW_DEF = 10;

endpackage

// File: rtl/mem_clr_seq.sv
// Clear sequencer: walks every address once, writing the clear value.
// Starts in CLEAR after reset; re-enters CLEAR on a clr request seen in IDLE.
// o_state exposes the FSM state for observation.
module mem_clr_seq
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clr,
  output logic           o_busy,
  output logic           o_clr_done,
  output logic           o_clr_we,
  output logic [AW-1:0]  o_clr_addr,
  output mem_clr_state_e o_state
);

  // Last address of the sweep (DEPTH-1 is all ones in AW bits).
  localparam logic [AW-1:0] LAST_ADDR = '1;

  mem_clr_state_e r_state;
  mem_clr_state_e w_state_nxt;
  logic [AW-1:0]  r_cnt;
  logic [AW-1:0]  w_cnt_nxt;
  logic           r_busy;
  logic           w_clr_done;
  logic           w_clr_we;

  // Next-state, sweep counter and sweep write strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_done  = 1'b0;
    w_clr_we    = 1'b0;
    case (r_state)
      MEM_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_clr_done  = 1'b1;
          w_state_nxt = MEM_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      MEM_IDLE: begin
        if (i_clr) begin
          w_state_nxt = MEM_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // State register; busy is registered from the next state so it tracks state==CLEAR exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MEM_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == MEM_CLEAR);
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_done = w_clr_done;
  assign o_clr_we   = w_clr_we;
  assign o_clr_addr = r_cnt;
  assign o_state    = r_state;

endmodule

// File: rtl/mem_kxn_clr.sv
// Single-port synchronous RAM (DW x 2**AW) with a hardware clear engine.
// Read-first on same-address read/write by default; define
// SYNC_RAM_WR_FIRST_EN for write-first read data (array/FSM unchanged).
module mem_kxn_clr
  import mem_pkg::*;
#(
  parameter int            DW      = MEM_DW_DEF,
  parameter int            AW      = MEM_AW_DEF,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_done,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] d_o
);

  localparam int DEPTH = 1 << AW;

  mem_clr_state_e w_state;
  logic           w_clr_we;
  logic [AW-1:0]  w_clr_addr;
  logic           w_idle;
  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic [DW-1:0]  w_wdata;
  logic [DW-1:0]  w_rd_data;
  logic [DW-1:0]  r_d_o;
  logic [DW-1:0]  r_mem [DEPTH];

  mem_clr_seq #(.AW(AW)) u_seq (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .o_busy     (busy),
    .o_clr_done (clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_state    (w_state)
  );

  // The user port only owns the array while the sweep is idle.
  assign w_idle  = (w_state == MEM_IDLE);
  assign w_we    = w_clr_we | (w_idle & wr);
  assign w_waddr = w_clr_we ? w_clr_addr : addr;
  assign w_wdata = w_clr_we ? CLR_VAL : d_i;

`ifdef SYNC_RAM_WR_FIRST_EN
  assign w_rd_data = wr ? d_i : r_mem[addr];
`else
  assign w_rd_data = r_mem[addr];
`endif

  // Single write port into the array (no reset; the sweep initialises it).
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read data; frozen while the sweep runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_o <= CLR_VAL;
    end else if (w_idle) begin
      r_d_o <= w_rd_data;
    end
  end

  assign d_o = r_d_o;

endmodule

// File: tb/tb_mem_kxn_clr.sv
// Bench for mem_kxn_clr: an 8x16 instance for directed tests and a
// 1x1024 (CLR_VAL=1) instance for the long sweep and random traffic.
module tb_mem_kxn_clr;

`ifdef SYNC_RAM_WR_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, clr8, wr8, busy8, done8;
  logic [3:0] addr8;
  logic [7:0] d8_i, d8_o;

  logic       rst1_n, clr1, wr1, busy1, done1;
  logic [9:0] addr1;
  logic [0:0] d1_i, d1_o;

  mem_kxn_clr #(.DW(8), .AW(4), .CLR_VAL(8'h00)) dut8 (
    .clk(clk), .rst_n(rst8_n), .clr(clr8), .busy(busy8), .clr_done(done8),
    .wr(wr8), .addr(addr8), .d_i(d8_i), .d_o(d8_o)
  );

  mem_kxn_clr #(.DW(1), .AW(10), .CLR_VAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .clr(clr1), .busy(busy1), .clr_done(done1),
    .wr(wr1), .addr(addr1), .d_i(d1_i), .d_o(d1_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic w8(input logic w, input logic [3:0] a, input logic [7:0] d);
    wr8   = w;
    addr8 = a;
    d8_i  = d;
    step();
  endtask

  // 16-cycle sweep on dut8 starting from CLEAR with count 0.
  task automatic sweep8(input string tag);
    for (int c = 0; c < 16; c++) begin
      chk({tag, " busy"}, busy8, 1);
      chk({tag, " done"}, done8, (c == 15));
      step();
    end
    chk({tag, " busy_end"}, busy8, 0);
    chk({tag, " done_end"}, done8, 0);
  endtask

  task automatic read_all8(input string tag, input logic [7:0] exp);
    w8(1'b0, 4'd0, 8'h00);
    for (int a = 1; a <= 16; a++) begin
      chk($sformatf("%s rd%0d", tag, a - 1), d8_o, exp);
      w8(1'b0, 4'(a), 8'h00);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] d;
    logic [7:0] exp_rf;
    logic [7:0] exp_wf;
  } vec_t;

  vec_t vecs[13];
  logic m1[1024];

  // Watchdog: the run is bounded well below this.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] ra;
    logic       rw, rd, e;
    int         cyc;

    vecs[0]  = '{1'b1, 4'd3,  8'hA5, 8'h00, 8'hA5};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, 8'hA5, 8'hA5};
    vecs[2]  = '{1'b1, 4'd7,  8'h11, 8'h00, 8'h11};
    vecs[3]  = '{1'b0, 4'd7,  8'h00, 8'h11, 8'h11};
    vecs[4]  = '{1'b1, 4'd7,  8'h22, 8'h11, 8'h22};
    vecs[5]  = '{1'b0, 4'd7,  8'h00, 8'h22, 8'h22};
    vecs[6]  = '{1'b1, 4'd0,  8'h5A, 8'h00, 8'h5A};
    vecs[7]  = '{1'b0, 4'd15, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 4'd0,  8'h00, 8'h5A, 8'h5A};
    vecs[9]  = '{1'b1, 4'd15, 8'hC3, 8'h00, 8'hC3};
    vecs[10] = '{1'b0, 4'd15, 8'h00, 8'hC3, 8'hC3};
    vecs[11] = '{1'b1, 4'd3,  8'h0F, 8'hA5, 8'h0F};
    vecs[12] = '{1'b0, 4'd3,  8'h00, 8'h0F, 8'h0F};

    rst8_n = 1'b0; clr8 = 1'b0; wr8 = 1'b0; addr8 = '0; d8_i = '0;
    rst1_n = 1'b0; clr1 = 1'b0; wr1 = 1'b0; addr1 = '0; d1_i = '0;
    repeat (3) step();

    // Reset state of both instances.
    chk("rst busy8", busy8, 1);
    chk("rst done8", done8, 0);
    chk("rst d_o8", d8_o, 8'h00);
    chk("rst busy1", busy1, 1);
    chk("rst d_o1", d1_o, 1);

    // 1: sweep after reset release, then everything reads zero.
    rst8_n = 1'b1;
    sweep8("reset_sweep");
    read_all8("post_reset", 8'h00);

    // 2/3: table-driven writes/reads including read-during-write.
    for (int i = 0; i < 13; i++) begin
      w8(vecs[i].wr, vecs[i].addr, vecs[i].d);
      chk($sformatf("vec%0d d_o", i), d8_o, WF ? vecs[i].exp_wf : vecs[i].exp_rf);
    end

    // 4: fill with FF, clear; mid-sweep wr and clr are ignored, d_o holds.
    for (int a = 0; a < 16; a++) w8(1'b1, 4'(a), 8'hFF);
    w8(1'b0, 4'd9, 8'h00);
    chk("fill rd9", d8_o, 8'hFF);
    clr8 = 1'b1;
    w8(1'b0, 4'd9, 8'h00);
    clr8 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("clr4 busy", busy8, 1);
      chk("clr4 done", done8, (c == 15));
      chk("clr4 d_o hold", d8_o, 8'hFF);
      clr8  = (c == 3 || c == 15);
      wr8   = (c == 10);
      addr8 = (c == 10) ? 4'd5 : 4'(c);
      d8_i  = 8'h3C;
      step();
    end
    clr8 = 1'b0;
    wr8  = 1'b0;
    chk("clr4 busy_end", busy8, 0);
    chk("clr4 done_end", done8, 0);
    read_all8("post_clr", 8'h00);

    // 5: reset at sweep word 6 restarts the sweep from 0.
    for (int a = 0; a < 16; a++) w8(1'b1, 4'(a), 8'h77);
    clr8 = 1'b1;
    w8(1'b0, 4'd0, 8'h00);
    clr8 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("pre_rst busy", busy8, 1);
      step();
    end
    rst8_n = 1'b0;
    #1;
    chk("mid_rst busy", busy8, 1);
    chk("mid_rst done", done8, 0);
    chk("mid_rst d_o", d8_o, 8'h00);
    step();
    chk("mid_rst busy c1", busy8, 1);
    step();
    chk("mid_rst busy c2", busy8, 1);
    rst8_n = 1'b1;
    sweep8("rst_restart");
    // First IDLE-cycle clr is honoured.
    clr8 = 1'b1;
    step();
    clr8 = 1'b0;
    sweep8("idle_clr");
    read_all8("post_restart", 8'h00);

    // 6: DW=1 AW=10, CLR_VAL=1: 1024-cycle sweep, then random traffic.
    rst1_n = 1'b1;
    cyc = 0;
    while (!done1 && cyc < 1100) begin
      step();
      cyc++;
    end
    chk("dw1 done_cycle", cyc, 1023);
    chk("dw1 busy_at_done", busy1, 1);
    step();
    chk("dw1 busy_end", busy1, 0);
    chk("dw1 done_end", done1, 0);

    for (int i = 0; i < 1024; i++) m1[i] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rw = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ra = 10'($urandom_range(0, 1023));
      else                           ra = 10'($urandom_range(0, 31));
      e = (rw && WF) ? rd : m1[ra];
      exp_q.push_back({7'b0, e});
      if (rw) m1[ra] = rd;
      wr1   = rw;
      addr1 = ra;
      d1_i  = rd;
      step();
      chk($sformatf("dw1 rand%0d a=%0d", i, ra), {31'b0, d1_o}, {24'b0, exp_q.pop_front()});
    end
    wr1 = 1'b0;
    chk("exp_q empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
